perf_report: RTL

PERF_REPORT -- requirements
Module: perf_report

---
 rtl/perf_report_if.sv | 13 +
 rtl/perf_report.sv | 137 +++++++++++++
 2 files changed

// File: rtl/perf_report_if.sv
// perf_report_if -- byte-stream transmit channel used by perf_report.
//   tx_data  : frame byte, driven by the master
//   tx_valid : tx_data carries a byte, driven by the master
//   tx_ready : consumer accepts the byte this edge, driven by the slave
// A byte moves on every rising clock edge where tx_valid and tx_ready are both 1.
interface perf_report_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/perf_report.sv
// perf_report -- packs the processor run statistics into a 22-byte frame when
// the run harness raises `done`.
// Frame: 0xA5 header, 20 payload bytes (num_inst, num_noops_min, num_noops_max,
// num_mispredicts, result; each least-significant byte first), then a checksum
// byte that makes the payload sum 0 mod 256.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   done              : run-complete flag; its rising edge starts a frame
//   num_inst .. result: 32-bit statistics, captured at the rising edge of done
//   tx                : byte-stream master (tx_data / tx_valid / tx_ready)
//   busy              : a frame is being sent
//   frames_sent       : completed frames, wraps 255 -> 0
//   frame_done        : high during the cycle the checksum byte transfers
module perf_report (
  input  logic              clock,
  input  logic              reset,
  input  logic              done,
  input  logic [31:0]       num_inst,
  input  logic [31:0]       num_noops_min,
  input  logic [31:0]       num_noops_max,
  input  logic [31:0]       num_mispredicts,
  input  logic [31:0]       result,
  perf_report_if.master     tx,
  output logic              busy,
  output logic [7:0]        frames_sent,
  output logic              frame_done
);

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, CHECK, HOLD} state_t;

  localparam logic [7:0] HEADER_BYTE  = 8'hA5;
  localparam logic [4:0] LAST_PAYLOAD = 5'd19;

  state_t       state, state_next;
  logic         done_d;
  logic         trigger;
  logic         xfer;
  logic [4:0]   byte_idx;
  // Payload image in transmit order: byte k of the payload is snap[8k +: 8].
  logic [159:0] snap;
  logic [7:0]   payload_byte;
  logic [7:0]   payload_sum;
  logic [7:0]   checksum;

  assign trigger = done & ~done_d;
  assign xfer    = tx.tx_valid & tx.tx_ready;

  // Data bytes come straight from the frozen snapshot, so tx_data cannot move
  // while the consumer stalls.
  assign payload_byte = snap[{byte_idx, 3'b000} +: 8];

  always_comb begin
    payload_sum = 8'd0;
    for (int i = 0; i < 20; i++) begin
      payload_sum = payload_sum + snap[8*i +: 8];
    end
  end

  assign checksum = 8'd0 - payload_sum;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      done_d      <= 1'b0;
      byte_idx    <= 5'd0;
      frames_sent <= 8'd0;
      // NOTE: the snapshot is an ordinary register bank, not a RAM, so it is
      // cleared on reset like the rest of the state.
      snap        <= '0;
    end else begin
      done_d <= done;
      if (state == IDLE && trigger) begin
        snap <= {result, num_mispredicts, num_noops_max, num_noops_min, num_inst};
      end
      if (state == HEADER && xfer) begin
        byte_idx <= 5'd0;
      end else if (state == PAYLOAD && xfer) begin
        byte_idx <= byte_idx + 5'd1;
      end
      if (state == CHECK && xfer) begin
        frames_sent <= frames_sent + 8'd1;
      end
    end
  end

  // Inside this block tx_ready alone qualifies a transfer: tx_valid is 1 in
  // every state that looks at it, and reading it here would form a loop.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_next  = state;
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'h00;
    busy        = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) state_next = HEADER;
      end
      HEADER: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = HEADER_BYTE;
        busy        = 1'b1;
        if (tx.tx_ready) state_next = PAYLOAD;
      end
      PAYLOAD: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = payload_byte;
        busy        = 1'b1;
        if (tx.tx_ready && byte_idx == LAST_PAYLOAD) state_next = CHECK;
      end
      CHECK: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = checksum;
        busy        = 1'b1;
        if (tx.tx_ready) begin
          frame_done = 1'b1;
          // With done still high, park in HOLD so the same level cannot retrigger.
          state_next = done ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (!done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
